// File: rtl/mul8_seq_ctrl_pkg.sv
// mul_seq_pkg: shared widths, step count and FSM encoding for the 8x8 nibble-serial multiplier.
package mul_seq_pkg;
  localparam int NIB_W = 4;
  localparam int OP_W = 2 * NIB_W;
  localparam int N_STEPS = 4;
  localparam int STEP_W = 2;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mul8_seq_ctrl_if.sv
// mul8_seq_ctrl_if: operand/product valid-ready handshake bundle plus busy status.
interface mul8_seq_ctrl_if import mul_seq_pkg::*; ();
  logic [OP_W-1:0] in_a;
  logic [OP_W-1:0] in_b;
  logic in_valid;
  logic in_ready;
  logic [2*OP_W-1:0] out_prod;
  logic out_valid;
  logic out_ready;
  logic busy;
  modport master (
    output in_a, in_b, in_valid, out_ready,
    input  in_ready, out_prod, out_valid, busy
  );
  modport slave (
    input  in_a, in_b, in_valid, out_ready,
    output in_ready, out_prod, out_valid, busy
  );
endinterface

// File: rtl/mul8_seq_ctrl_mult.sv
// array_mult4: combinational unsigned 4x4 -> 8 ripple array multiplier, three rows of four full adders.
module array_mult4 import mul_seq_pkg::*; (
  input  logic [NIB_W-1:0]   a_i,
  input  logic [NIB_W-1:0]   b_i,
  output logic [2*NIB_W-1:0] p_o
);
  // One array row: previous row's upper sum bits plus the next partial-product row.
  function automatic logic [NIB_W:0] row_add(input logic [NIB_W-1:0] x, input logic [NIB_W-1:0] y);
    logic c;
    row_add = '0;
    c = 1'b0;
    for (int j = 0; j < NIB_W; j++) begin
      row_add[j] = x[j] ^ y[j] ^ c;
      c = (x[j] & y[j]) | (c & (x[j] ^ y[j]));
    end
    row_add[NIB_W] = c;
  endfunction
  logic [NIB_W:0] r0, r1, r2, r3;
  assign r0 = {1'b0, a_i & {NIB_W{b_i[0]}}};
  assign r1 = row_add(r0[NIB_W:1], a_i & {NIB_W{b_i[1]}});
  assign r2 = row_add(r1[NIB_W:1], a_i & {NIB_W{b_i[2]}});
  assign r3 = row_add(r2[NIB_W:1], a_i & {NIB_W{b_i[3]}});
  assign p_o = {r3, r2[0], r1[0], r0[0]};
endmodule

// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: sequences one 4x4 array multiplier over four nibble-pair steps to form an 8x8 product.
module mul8_seq_ctrl import mul_seq_pkg::*; (
  input logic clk,
  input logic rst_n,
  input logic ena,
  mul8_seq_ctrl_if.slave bus
);
  state_t state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [OP_W-1:0] a_q, a_d, b_q, b_d;
  logic [2*OP_W-1:0] acc_q, acc_d, term;
  logic [NIB_W-1:0] a_nib, b_nib;
  logic [2*NIB_W-1:0] pp;
  logic accept;
  assign bus.in_ready = ena & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
  assign accept = bus.in_valid & bus.in_ready;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy = state_q == MUL;
  assign bus.out_prod = acc_q;
  assign a_nib = step_q[0] ? a_q[7:4] : a_q[3:0];
  assign b_nib = step_q[1] ? b_q[7:4] : b_q[3:0];
  array_mult4 u_mult (
    .a_i(a_nib),
    .b_i(b_nib),
    .p_o(pp)
  );
  // Weight of the partial product is 2^(4*(step[0]+step[1])).
  assign term = (step_q == 2'd3) ? {pp, 8'h00} : (^step_q) ? {4'h0, pp, 4'h0} : {8'h00, pp};
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = MUL;
          a_d = bus.in_a;
          b_d = bus.in_b;
          acc_d = '0;
          step_d = '0;
        end else if (state_q == DONE && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      MUL: begin
        acc_d = acc_q + term;
        step_d = step_q + 1'b1;
        state_d = (step_q == STEP_W'(N_STEPS - 1)) ? DONE : MUL;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
    end else if (ena) begin
      state_q <= state_d;
      step_q <= step_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb_mul8_seq_ctrl: vector table, handshake corner sequences and random operands checked against a*b.
module tb_mul8_seq_ctrl;
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n, ena;
  int cyc = 0, n_chk = 0, n_fail = 0, t_acc = 0;
  vec_t vecs [8];
  mul8_seq_ctrl_if bus();
  mul8_seq_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    chk("in_ready before issue", 32'(bus.in_ready), 32'd1);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    t_acc = cyc;
    chk("busy after accept", 32'(bus.busy), 32'd1);
  endtask
  task automatic wait_done(output int lat);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    lat = cyc - t_acc;
    chk("out_valid within bound", 32'(bus.out_valid), 32'd1);
  endtask
  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, t_prev, seen;
    logic [15:0] held, want;
    logic [7:0] ra, rb;
    vecs[0] = '{8'h0F, 8'h0F, 16'h00E1};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'hA5, 8'h3C, 16'h26AC};
    vecs[3] = '{8'h00, 8'hC3, 16'h0000};
    vecs[4] = '{8'h37, 8'h59, 16'h131F};
    vecs[5] = '{8'h10, 8'h10, 16'h0100};
    vecs[6] = '{8'h01, 8'hFF, 16'h00FF};
    vecs[7] = '{8'h80, 8'h02, 16'h0100};
    rst_n = 1'b0;
    ena = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    tick();
    tick();
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset out_prod", 32'(bus.out_prod), 32'd0);
    chk("in_ready forced low by ena", 32'(bus.in_ready), 32'd0);
    ena = 1'b1;
    #1;
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done(lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d out_prod", i), 32'(bus.out_prod), 32'(vecs[i].p));
      consume();
      chk($sformatf("vec%0d idle after consume", i), 32'(bus.out_valid), 32'd0);
    end
    issue(8'h0F, 8'h0F);
    wait_done(lat);
    held = bus.out_prod;
    bus.in_a = 8'h12;
    bus.in_b = 8'h34;
    bus.in_valid = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (bus.out_prod !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.busy !== 1'b0) seen++;
    end
    chk("hold cycles disturbed", 32'(seen), 32'd0);
    chk("held out_prod", 32'(bus.out_prod), 32'h00E1);
    bus.in_valid = 1'b0;
    consume();
    chk("blocked operands not accepted", 32'(bus.busy), 32'd0);
    issue(8'hA5, 8'h3C);
    wait_done(lat);
    t_prev = cyc;
    chk("b2b first product", 32'(bus.out_prod), 32'h26AC);
    bus.in_a = 8'h10;
    bus.in_b = 8'h10;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("b2b in_ready in DONE", 32'(bus.in_ready), 32'd1);
    tick();
    t_acc = cyc;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b busy", 32'(bus.busy), 32'd1);
    wait_done(lat);
    chk("b2b spacing", 32'(cyc - t_prev), 32'd5);
    chk("b2b second product", 32'(bus.out_prod), 32'h0100);
    consume();
    issue(8'hFF, 8'h02);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid reset busy", 32'(bus.busy), 32'd0);
    chk("mid reset acc", 32'(bus.out_prod), 32'd0);
    chk("mid reset in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    repeat (8) begin
      tick();
      if (bus.out_valid !== 1'b0) seen++;
    end
    chk("no stale product", 32'(seen), 32'd0);
    issue(8'h37, 8'h59);
    tick();
    ena = 1'b0;
    #1;
    chk("ena low in_ready", 32'(bus.in_ready), 32'd0);
    held = bus.out_prod;
    seen = 0;
    repeat (3) begin
      tick();
      if (bus.out_prod !== held || bus.busy !== 1'b1) seen++;
    end
    chk("frozen during ena low", 32'(seen), 32'd0);
    ena = 1'b1;
    wait_done(lat);
    chk("ena stretched latency", 32'(lat), 32'd7);
    chk("ena product", 32'(bus.out_prod), 32'h131F);
    consume();
    for (int k = 0; k < 40; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      want = {8'h00, ra} * {8'h00, rb};
      repeat ($urandom_range(0, 2)) tick();
      issue(ra, rb);
      wait_done(lat);
      chk("rand latency", 32'(lat), 32'd4);
      repeat ($urandom_range(0, 3)) tick();
      chk($sformatf("rand %0h*%0h", ra, rb), 32'(bus.out_prod), 32'(want));
      consume();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
